// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32 multicycle controller and its opcode decoders.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_TRAP = 3'd7
   } state_e;

   typedef enum logic [3:0] {
      CL_OP     = 4'd0,
      CL_OPIMM  = 4'd1,
      CL_LUI    = 4'd2,
      CL_AUIPC  = 4'd3,
      CL_LOAD   = 4'd4,
      CL_STORE  = 4'd5,
      CL_BRANCH = 4'd6,
      CL_JAL    = 4'd7,
      CL_JALR   = 4'd8
   } class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
   localparam logic [1:0] CAUSE_IF_TO   = 2'd1;
   localparam logic [1:0] CAUSE_EX_TO   = 2'd2;
   localparam logic [1:0] CAUSE_MEM_TO  = 2'd3;

   // Stores and branches are the only classes that leave the register file untouched.
   function automatic logic class_writes_rd(input class_e cls);
      return !((cls == CL_STORE) || (cls == CL_BRANCH));
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class plus an illegal flag.
module mc_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output class_e     cls_o,
   output logic       illegal_o
);

   // Unknown opcodes raise illegal and report the harmless OP class.
   always_comb begin
      cls_o     = CL_OP;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_LOAD:   cls_o = CL_LOAD;
         OPC_STORE:  cls_o = CL_STORE;
         OPC_OP:     cls_o = CL_OP;
         OPC_OPIMM:  cls_o = CL_OPIMM;
         OPC_BRANCH: cls_o = CL_BRANCH;
         OPC_JAL:    cls_o = CL_JAL;
         OPC_JALR:   cls_o = CL_JALR;
         OPC_LUI:    cls_o = CL_LUI;
         OPC_AUIPC:  cls_o = CL_AUIPC;
         default:    illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32 main controller (IF/ID/EX/MEM/WB/TRAP) with stall timeouts.
// Define MC_CTRL_PERF_EN to build the instret/stallcnt retire and stall counters.
module mc_controller
   import ctrl_pkg::*;
#(
   parameter int pcmux_N  = 2,
   parameter int WAIT_MAX = 64,
   parameter int CNT_W    = 32
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [6:0]                   opcode,
   input  logic                         imem_valid,
   input  logic                         exdone,
   input  logic                         brtaken,
   input  logic                         mem_ack,
   input  logic                         trap_clr,
   output logic [$clog2(pcmux_N)-1:0]   pcmuxctl,
   output logic                         pcnextctl,
   output logic                         instrre,
   output logic                         memre,
   output logic                         memwe,
   output logic                         regwe,
   output logic                         trap,
   output logic [1:0]                   trap_cause,
   output logic [CNT_W-1:0]             instret,
   output logic [CNT_W-1:0]             stallcnt
);

   localparam int          PW       = $clog2(pcmux_N);
   localparam int          WW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
   localparam logic [WW:0] WAIT_LIM = (WW + 1)'(WAIT_MAX);
   localparam bit          TO_EN    = (WAIT_MAX > 0);

   state_e        state_q, state_d;
   class_e        class_q, class_d;
   logic          taken_q, taken_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [1:0]    cause_q, cause_d;

   class_e        dec_cls_s;
   logic          dec_illegal_s;
   logic          in_wait_s;
   logic          hs_s;
   logic          stall_s;
   logic          timeout_s;
   logic          pc_sel_s;

   mc_decode u_decode (
      .opcode_i  (opcode),
      .cls_o     (dec_cls_s),
      .illegal_o (dec_illegal_s)
   );

   // Handshake qualifying the current wait state, and the stall/timeout conditions it implies.
   always_comb begin
      hs_s      = 1'b0;
      in_wait_s = 1'b1;
      case (state_q)
         ST_IF:   hs_s = imem_valid;
         ST_EX:   hs_s = exdone;
         ST_MEM:  hs_s = mem_ack;
         default: in_wait_s = 1'b0;
      endcase
      stall_s   = in_wait_s && !hs_s;
      // A handshake in the limit cycle wins because timeout only fires on a stall cycle.
      timeout_s = TO_EN && stall_s && (({1'b0, wait_q} + (WW + 1)'(1'b1)) == WAIT_LIM);
   end

   // Next-state logic for the sequencer and its latched instruction context.
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      taken_d = taken_q;
      cause_d = cause_q;
      case (state_q)
         ST_IF: begin
            if (imem_valid) begin
               state_d = ST_ID;
            end else if (timeout_s) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_IF_TO;
            end else begin
               state_d = ST_IF;
            end
         end
         ST_ID: begin
            class_d = dec_cls_s;
            taken_d = 1'b0;
            if (dec_illegal_s) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = ST_EX;
            end
         end
         ST_EX: begin
            if (exdone) begin
               taken_d = (class_q == CL_BRANCH) && brtaken;
               state_d = ((class_q == CL_LOAD) || (class_q == CL_STORE)) ? ST_MEM : ST_WB;
            end else if (timeout_s) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_EX_TO;
            end else begin
               state_d = ST_EX;
            end
         end
         ST_MEM: begin
            if (mem_ack) begin
               state_d = ST_WB;
            end else if (timeout_s) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_MEM_TO;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB:   state_d = ST_IF;
         ST_TRAP: begin
            if (trap_clr) begin
               state_d = ST_IF;
            end else begin
               state_d = ST_TRAP;
            end
         end
         default: state_d = ST_IF;
      endcase

      if ((state_d != state_q) || !in_wait_s) begin
         wait_d = {WW{1'b0}};
      end else begin
         wait_d = wait_q + WW'(1'b1);
      end
   end

   // Sequencer state and latched context registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IF;
         class_q <= CL_OP;
         taken_q <= 1'b0;
         wait_q  <= {WW{1'b0}};
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         taken_q <= taken_d;
         wait_q  <= wait_d;
         cause_q <= cause_d;
      end
   end

   // Moore output decode from the state register and latched class/taken flag.
   always_comb begin
      instrre   = 1'b0;
      memre     = 1'b0;
      memwe     = 1'b0;
      regwe     = 1'b0;
      pcnextctl = 1'b0;
      pc_sel_s  = 1'b0;
      trap      = 1'b0;
      case (state_q)
         ST_IF:   instrre = 1'b1;
         ST_MEM: begin
            memre = (class_q == CL_LOAD);
            memwe = (class_q == CL_STORE);
         end
         ST_WB: begin
            pcnextctl = 1'b1;
            regwe     = class_writes_rd(class_q);
            pc_sel_s  = (class_q == CL_JAL) || (class_q == CL_JALR) ||
                        ((class_q == CL_BRANCH) && taken_q);
         end
         ST_TRAP: trap = 1'b1;
         default: instrre = 1'b0;
      endcase
      pcmuxctl   = PW'(pc_sel_s);
      trap_cause = cause_q;
   end

`ifdef MC_CTRL_PERF_EN
   logic [CNT_W-1:0] instret_q;
   logic [CNT_W-1:0] stallcnt_q;

   // Retire and stall counters, wrapping modulo 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q  <= {CNT_W{1'b0}};
         stallcnt_q <= {CNT_W{1'b0}};
      end else begin
         if (state_q == ST_WB) begin
            instret_q <= instret_q + CNT_W'(1'b1);
         end
         if (stall_s) begin
            stallcnt_q <= stallcnt_q + CNT_W'(1'b1);
         end
      end
   end

   assign instret  = instret_q;
   assign stallcnt = stallcnt_q;
`else
   assign instret  = {CNT_W{1'b0}};
   assign stallcnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected per-cycle output vectors are queued then compared.
`timescale 1ns/1ps
module tb_mc_controller;

   localparam int CW = 32;
`ifdef MC_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [6:0]    opcode = 7'd0;
   logic          imem_valid = 1'b0, exdone = 1'b0, brtaken = 1'b0, mem_ack = 1'b0, trap_clr = 1'b0;
   logic [0:0]    pcmuxctl;
   logic          pcnextctl, instrre, memre, memwe, regwe, trap;
   logic [1:0]    trap_cause;
   logic [CW-1:0] instret, stallcnt;

   logic [12:0]   obs, exp_v;
   logic [12:0]   sbq[$];
   int            n_checks = 0;
   int            n_pass = 0;
   logic [CW-1:0] exp_instret = '0;
   logic [CW-1:0] exp_stall = '0;
   logic [1:0]    cur_cause = 2'd0;

   mc_controller #(.pcmux_N(2), .WAIT_MAX(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_valid(imem_valid),
      .exdone(exdone), .brtaken(brtaken), .mem_ack(mem_ack), .trap_clr(trap_clr),
      .pcmuxctl(pcmuxctl), .pcnextctl(pcnextctl), .instrre(instrre), .memre(memre),
      .memwe(memwe), .regwe(regwe), .trap(trap), .trap_cause(trap_cause),
      .instret(instret), .stallcnt(stallcnt)
   );

   always #5 clk = ~clk;

   assign obs = {dut.state_q, instrre, memre, memwe, regwe, pcnextctl, pcmuxctl[0], trap, trap_cause};

   function automatic logic [12:0] ev(input logic [2:0] st, input logic ir, input logic mr,
                                      input logic mw, input logic rw, input logic pn,
                                      input logic pm, input logic tr, input logic [1:0] cs);
      return {st, ir, mr, mw, rw, pn, pm, tr, cs};
   endfunction
   function automatic logic [12:0] e_if(input logic [1:0] cs);
      return ev(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cs);
   endfunction
   function automatic logic [12:0] e_id(input logic [1:0] cs);
      return ev(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cs);
   endfunction
   function automatic logic [12:0] e_ex(input logic [1:0] cs);
      return ev(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, cs);
   endfunction
   function automatic logic [12:0] e_mem(input logic mr, input logic mw, input logic [1:0] cs);
      return ev(3'd3, 1'b0, mr, mw, 1'b0, 1'b0, 1'b0, 1'b0, cs);
   endfunction
   function automatic logic [12:0] e_wb(input logic rw, input logic pm, input logic [1:0] cs);
      return ev(3'd4, 1'b0, 1'b0, 1'b0, rw, 1'b1, pm, 1'b0, cs);
   endfunction
   function automatic logic [12:0] e_trap(input logic [1:0] cs);
      return ev(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, cs);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      sbq.push_back(e_if(2'd0));
      exp_v = sbq.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL reset_outputs: got %b want %b", obs, exp_v);
      else n_pass++;
      n_checks++;
      if (instret !== '0 || stallcnt !== '0) $display("FAIL reset_counters: got %0d/%0d want 0/0", instret, stallcnt);
      else n_pass++;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      opcode = 7'b0110011; imem_valid = 1'b1; exdone = 1'b1; mem_ack = 1'b1; brtaken = 1'b0;
      trap_clr = 1'b1;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause));
      sbq.push_back(e_ex(cur_cause)); sbq.push_back(e_wb(1'b1, 1'b0, cur_cause));
      for (int i = 0; i < 4; i++) begin
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL add cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      trap_clr = 1'b0;
      exp_instret++;
      n_checks++;
      if (instret !== (PERF ? exp_instret : '0)) $display("FAIL add_instret: got %0d want %0d", instret, PERF ? exp_instret : '0);
      else n_pass++;
   endtask

   task automatic test_load_stall();
      opcode = 7'b0000011; imem_valid = 1'b1; exdone = 1'b1;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause)); sbq.push_back(e_ex(cur_cause));
      for (int k = 0; k < 4; k++) sbq.push_back(e_mem(1'b1, 1'b0, cur_cause));
      sbq.push_back(e_wb(1'b1, 1'b0, cur_cause));
      for (int i = 0; i < 8; i++) begin
         mem_ack = (i == 6);
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL load_stall cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      exp_instret++;
      exp_stall += 3;
      n_checks++;
      if (stallcnt !== (PERF ? exp_stall : '0)) $display("FAIL load_stallcnt: got %0d want %0d", stallcnt, PERF ? exp_stall : '0);
      else n_pass++;
   endtask

   task automatic test_branch(input logic taken);
      opcode = 7'b1100011; imem_valid = 1'b1; exdone = 1'b1; mem_ack = 1'b1;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause));
      sbq.push_back(e_ex(cur_cause)); sbq.push_back(e_wb(1'b0, taken, cur_cause));
      for (int i = 0; i < 4; i++) begin
         brtaken = (i == 2) ? taken : !taken;
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL branch_t%0d cyc%0d: got %b want %b", taken, i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      exp_instret++;
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      imem_valid = 1'b1; exdone = 1'b1; mem_ack = 1'b1; brtaken = 1'b1; trap_clr = 1'b1;
      for (int k = 0; k < 9; k++) begin
         logic mr, mw, rw, pm;
         int n;
         mr = 1'b0; mw = 1'b0; rw = 1'b1; pm = 1'b0;
         case (ops[k])
            7'b0000011: mr = 1'b1;
            7'b0100011: begin mw = 1'b1; rw = 1'b0; end
            7'b1100011: begin rw = 1'b0; pm = 1'b1; end
            7'b1101111, 7'b1100111: pm = 1'b1;
            default: rw = 1'b1;
         endcase
         opcode = ops[k];
         sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause)); sbq.push_back(e_ex(cur_cause));
         if (mr || mw) sbq.push_back(e_mem(mr, mw, cur_cause));
         sbq.push_back(e_wb(rw, pm, cur_cause));
         n = (mr || mw) ? 5 : 4;
         for (int i = 0; i < n; i++) begin
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs !== exp_v) $display("FAIL b2b op%b cyc%0d: got %b want %b", ops[k], i, obs, exp_v);
            else n_pass++;
            @(negedge clk);
         end
         exp_instret++;
      end
      trap_clr = 1'b0; brtaken = 1'b0;
      n_checks++;
      if (instret !== (PERF ? exp_instret : '0)) $display("FAIL b2b_instret: got %0d want %0d", instret, PERF ? exp_instret : '0);
      else n_pass++;
   endtask

   task automatic test_timeout(input int stage);
      int n;
      opcode = (stage == 3) ? 7'b0100011 : 7'b0110011;
      imem_valid = (stage != 1); exdone = (stage != 2); mem_ack = (stage != 3); trap_clr = 1'b0;
      if (stage >= 2) begin sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause)); end
      if (stage == 3) sbq.push_back(e_ex(cur_cause));
      for (int k = 0; k < 4; k++) begin
         if (stage == 1) sbq.push_back(e_if(cur_cause));
         else if (stage == 2) sbq.push_back(e_ex(cur_cause));
         else sbq.push_back(e_mem(1'b0, 1'b1, cur_cause));
      end
      cur_cause = 2'(stage);
      sbq.push_back(e_trap(cur_cause)); sbq.push_back(e_trap(cur_cause));
      n = sbq.size();
      for (int i = 0; i < n; i++) begin
         trap_clr = (i == n - 1);
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL timeout_s%0d cyc%0d: got %b want %b", stage, i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      trap_clr = 1'b0;
      exp_stall += 4;
   endtask

   task automatic test_ex_limit_handshake();
      opcode = 7'b0110011; imem_valid = 1'b1; mem_ack = 1'b1;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause));
      for (int k = 0; k < 4; k++) sbq.push_back(e_ex(cur_cause));
      sbq.push_back(e_wb(1'b1, 1'b0, cur_cause));
      for (int i = 0; i < 7; i++) begin
         exdone = (i == 5);
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL ex_limit cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      exp_instret++;
      exp_stall += 3;
      n_checks++;
      if (stallcnt !== (PERF ? exp_stall : '0)) $display("FAIL ex_limit_stallcnt: got %0d want %0d", stallcnt, PERF ? exp_stall : '0);
      else n_pass++;
   endtask

   task automatic test_illegal();
      opcode = 7'b1111111; imem_valid = 1'b1; exdone = 1'b1; mem_ack = 1'b1;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause));
      cur_cause = 2'd0;
      sbq.push_back(e_trap(cur_cause)); sbq.push_back(e_trap(cur_cause));
      sbq.push_back(e_if(cur_cause));
      for (int i = 0; i < 5; i++) begin
         trap_clr = (i == 3);
         if (i == 4) imem_valid = 1'b0;
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL illegal cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      trap_clr = 1'b0;
      imem_valid = 1'b1;
      exp_stall += 1;
   endtask

   task automatic test_reset_mid_mem();
      opcode = 7'b0100011; imem_valid = 1'b1; exdone = 1'b1; mem_ack = 1'b0;
      sbq.push_back(e_if(cur_cause)); sbq.push_back(e_id(cur_cause)); sbq.push_back(e_ex(cur_cause));
      sbq.push_back(e_mem(1'b0, 1'b1, cur_cause));
      for (int i = 0; i < 4; i++) begin
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL mid_mem cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      cur_cause = 2'd0; exp_instret = '0; exp_stall = '0;
      sbq.push_back(e_if(cur_cause));
      exp_v = sbq.pop_front();
      n_checks++;
      if (obs !== exp_v) $display("FAIL mid_mem_async_reset: got %b want %b", obs, exp_v);
      else n_pass++;
      n_checks++;
      if (instret !== '0) $display("FAIL mid_mem_instret: got %0d want 0", instret);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1; imem_valid = 1'b0; mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) sbq.push_back(e_if(cur_cause));
      for (int i = 0; i < 3; i++) begin
         exp_v = sbq.pop_front();
         n_checks++;
         if (obs !== exp_v) $display("FAIL post_reset cyc%0d: got %b want %b", i, obs, exp_v);
         else n_pass++;
         @(negedge clk);
      end
      exp_stall += 3;
      n_checks++;
      if (stallcnt !== (PERF ? exp_stall : '0) || instret !== '0)
         $display("FAIL post_reset_counters: got %0d/%0d want %0d/0", stallcnt, instret, PERF ? exp_stall : '0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_load_stall();
      test_branch(1'b1);
      test_branch(1'b0);
      test_back_to_back();
      test_timeout(1);
      test_timeout(2);
      test_timeout(3);
      test_ex_limit_handshake();
      test_illegal();
      test_reset_mid_mem();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
